spi_slave_apb: RTL and testbench



---
 rtl/spi_slave_apb.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_slave_apb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_apb.sv
// spi_slave_apb: APB3 slave acting as an SPI mode-0 responder (MSB first).
// Firmware loads a response word through TXDATA and collects received words
// through RXDATA. SCK, SS_N and MOSI are synchronized into PCLK.
//
// Ports:
//   PCLK, PRESERN       clock, async active-low reset
//   PSEL..PWDATA        APB3 request (PADDR[3:2] decoded)
//   PREADY, PSLVERR     tied 1 / 0
//   PRDATA              combinational read mux
//   SCK, SS_N, MOSI     SPI inputs from the master (async to PCLK)
//   MISO, MISO_OE       SPI data out and pad enable
//   IRQ                 registered interrupt (only with SPI_SLV_IRQ_EN)
//
// Register map: 0x0 TXDATA (wo), 0x4 RXDATA (ro), 0x8 STATUS (ro), 0xC CTRL.
// Optional feature macro: SPI_SLV_IRQ_EN adds IRQ and CTRL[3:2] enables.
//
// state | meaning
// IDLE  | not selected (or disabled); MISO_OE low, MISO high
// LOAD  | one cycle: fetch TX word (or idle word), clear bit count
// SHIFT | shifting a frame on synced SCK edges
module spi_slave_apb #(
  parameter int                 FRAME_W     = 8,
  parameter logic [FRAME_W-1:0] IDLE_WORD   = '1,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] PRDATA,
  input  logic        SCK,
  input  logic        SS_N,
  input  logic        MOSI,
  output logic        MISO,
`ifdef SPI_SLV_IRQ_EN
  output logic        IRQ,
`endif
  output logic        MISO_OE
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  localparam logic [4:0] FRAME_END = 5'(FRAME_W);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  logic [FRAME_W-1:0]     shift_tx_q, shift_tx_d;
  logic [FRAME_W-1:0]     shift_rx_q, shift_rx_d;
  logic [4:0]             bitcnt_q, bitcnt_d;
  logic [FRAME_W-1:0]     txdata_q, txdata_d;
  logic [FRAME_W-1:0]     rxdata_q, rxdata_d;
  logic                   tx_full_q, tx_full_d;
  logic                   rx_full_q, rx_full_d;
  logic                   rx_ovr_q, rx_ovr_d;
  logic                   en_q, en_d;
  logic [1:0]             ien_q, ien_d;

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, ss_fall, ss_rise;
  logic apb_wr, apb_rd_rx;
  logic unused;

  assign unused = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:2]};

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;

  assign apb_wr    = PSEL & PENABLE & PWRITE;
  assign apb_rd_rx = PSEL & PENABLE & ~PWRITE & (PADDR[3:2] == 2'd1);

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign MISO_OE = (state_q != IDLE);
  assign MISO    = (state_q == SHIFT) ? shift_tx_q[FRAME_W-1] : 1'b1;

  always_comb begin
    PRDATA = 32'h0;
    if (PSEL && !PWRITE) begin
      case (PADDR[3:2])
        2'd1:    PRDATA = {{(32-FRAME_W){1'b0}}, rxdata_q};
        2'd2:    PRDATA = {24'h0, bitcnt_q[3:0], ~ss_s, rx_ovr_q, ~tx_full_q, rx_full_q};
        2'd3:    PRDATA = {28'h0, ien_q, 1'b0, en_q};
        default: PRDATA = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_N};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    bitcnt_d    = bitcnt_q;
    txdata_d    = txdata_q;
    rxdata_d    = rxdata_q;
    tx_full_d   = tx_full_q;
    rx_full_d   = rx_full_q;
    rx_ovr_d    = rx_ovr_q;
    en_d        = en_q;
    ien_d       = ien_q;

    // Clears come first so a same-cycle frame end can set the flags again.
    if (apb_rd_rx) rx_full_d = 1'b0;
    if (apb_wr && PADDR[3:2] == 2'd3) begin
      en_d = PWDATA[0];
      if (PWDATA[1]) rx_ovr_d = 1'b0;
`ifdef SPI_SLV_IRQ_EN
      ien_d = PWDATA[3:2];
`endif
    end

    case (state_q)
      IDLE: begin
        bitcnt_d = 5'd0;
        if (ss_fall && en_q) state_d = LOAD;
      end
      LOAD: begin
        shift_tx_d = tx_full_q ? txdata_q : IDLE_WORD;
        tx_full_d  = 1'b0;
        bitcnt_d   = 5'd0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (bitcnt_q == FRAME_END) begin
          // A word being read out this cycle frees the slot for the new one.
          if (rx_full_q && !apb_rd_rx) begin
            rx_ovr_d = 1'b1;
          end else begin
            rxdata_d  = shift_rx_q;
            rx_full_d = 1'b1;
          end
          state_d = LOAD;
        end else begin
          if (sck_rise) begin
            shift_rx_d = {shift_rx_q[FRAME_W-2:0], mosi_s};
            bitcnt_d   = bitcnt_q + 5'd1;
          end
          // bitcnt 0 filters the trailing fall of the previous frame.
          if (sck_fall && bitcnt_q != 5'd0)
            shift_tx_d = {shift_tx_q[FRAME_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    if (ss_rise) begin
      state_d  = IDLE;
      bitcnt_d = 5'd0;
    end

    // A firmware write in the LOAD cycle queues a fresh word.
    if (apb_wr && PADDR[3:2] == 2'd0) begin
      txdata_d  = PWDATA[FRAME_W-1:0];
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      bitcnt_q    <= 5'd0;
      txdata_q    <= '0;
      rxdata_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_full_q   <= 1'b0;
      rx_ovr_q    <= 1'b0;
      en_q        <= 1'b0;
      ien_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      bitcnt_q    <= bitcnt_d;
      txdata_q    <= txdata_d;
      rxdata_q    <= rxdata_d;
      tx_full_q   <= tx_full_d;
      rx_full_q   <= rx_full_d;
      rx_ovr_q    <= rx_ovr_d;
      en_q        <= en_d;
      ien_q       <= ien_d;
    end
  end

`ifdef SPI_SLV_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (rx_full_q & ien_q[0]) | (~tx_full_q & ien_q[1]) | rx_ovr_q;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_spi_slave_apb.sv
// tb_spi_slave_apb: directed bench for spi_slave_apb (FRAME_W = 8).
// Drives APB register accesses and an SPI mode-0 master, compares against
// hand-computed values.
module tb_spi_slave_apb;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'h0, PWDATA = 32'h0;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic        SCK = 1'b0, SS_N = 1'b1, MOSI = 1'b0;
  logic        MISO, MISO_OE;
`ifdef SPI_SLV_IRQ_EN
  logic        IRQ;
`endif

  int n_checks = 0;
  int n_errors = 0;

  spi_slave_apb dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .PRDATA  (PRDATA),
    .SCK     (SCK),
    .SS_N    (SS_N),
    .MOSI    (MOSI),
    .MISO    (MISO),
`ifdef SPI_SLV_IRQ_EN
    .IRQ     (IRQ),
`endif
    .MISO_OE (MISO_OE)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 data = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic ss_low();
    SS_N = 1'b0;
    #100;
  endtask

  task automatic ss_high();
    #100;
    SS_N = 1'b1;
    #100;
  endtask

  // Mode 0: data set while SCK low, both sides sample on the rising edge.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      MOSI = tx[7-k];
      #50;
      rx[7-k] = MISO;
      SCK = 1'b1;
      #50;
      SCK = 1'b0;
    end
  endtask

  logic [31:0] rd;
  logic [7:0]  mi;

  initial begin
    #12;
    check("rst_miso", {31'h0, MISO}, 32'h1);
    check("rst_miso_oe", {31'h0, MISO_OE}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("pready", {31'h0, PREADY}, 32'h1);
    check("pslverr", {31'h0, PSLVERR}, 32'h0);
    PRESERN = 1'b1;
    apb_read(32'h8, rd);  check("rst_status", rd, 32'h02);
    apb_read(32'hC, rd);  check("rst_ctrl", rd, 32'h00);

    // Loaded TX word, one frame
    apb_write(32'hC, 32'h1);
    apb_write(32'h0, 32'hA5);
    apb_read(32'h8, rd);  check("status_txfull", rd, 32'h00);
    ss_low();
    check("oe_selected", {31'h0, MISO_OE}, 32'h1);
    spi_xfer(8'h3C, 8, mi);
    check("miso_a5", {24'h0, mi}, 32'hA5);
    ss_high();
    check("miso_idle", {31'h0, MISO}, 32'h1);
    check("oe_idle", {31'h0, MISO_OE}, 32'h0);
    apb_read(32'h8, rd);  check("status_rxfull", rd, 32'h03);
    apb_read(32'h4, rd);  check("rx_3c", rd, 32'h3C);
    apb_read(32'h8, rd);  check("status_after_rd", rd, 32'h02);

    // No TX pending: idle word shifted out
    ss_low();
    spi_xfer(8'h81, 8, mi);
    ss_high();
    check("miso_ff", {24'h0, mi}, 32'hFF);
    apb_read(32'h4, rd);  check("rx_81", rd, 32'h81);

    // Back-to-back frames without reading: overrun keeps first word
    ss_low();
    spi_xfer(8'h11, 8, mi);
    spi_xfer(8'h22, 8, mi);
    ss_high();
    apb_read(32'h8, rd);  check("status_ovr", rd, 32'h07);
    apb_read(32'h4, rd);  check("rx_11", rd, 32'h11);
    apb_write(32'hC, 32'h3);
    apb_read(32'h8, rd);  check("status_ovr_clr", rd, 32'h02);
    apb_read(32'hC, rd);  check("ctrl_en_kept", rd, 32'h01);

    // TX overwrite while full
    apb_write(32'h0, 32'h12);
    apb_write(32'h0, 32'h34);
    ss_low();
    spi_xfer(8'h00, 8, mi);
    ss_high();
    check("miso_34", {24'h0, mi}, 32'h34);
    apb_read(32'h4, rd);  check("rx_00", rd, 32'h00);

    // Aborted frame after 5 bits
    ss_low();
    spi_xfer(8'hF0, 5, mi);
    #40;
    apb_read(32'h8, rd);  check("status_partial", rd, 32'h5A);
    ss_high();
    apb_read(32'h8, rd);  check("status_abort", rd, 32'h02);
    ss_low();
    spi_xfer(8'h5A, 8, mi);
    ss_high();
    apb_read(32'h8, rd);  check("status_5a", rd, 32'h03);
    apb_read(32'h4, rd);  check("rx_5a", rd, 32'h5A);

    // Disabled: SS ignored
    apb_write(32'hC, 32'h0);
    ss_low();
    check("oe_disabled", {31'h0, MISO_OE}, 32'h0);
    spi_xfer(8'h77, 8, mi);
    ss_high();
    check("miso_disabled", {24'h0, mi}, 32'hFF);
    apb_read(32'h8, rd);  check("status_disabled", rd, 32'h02);

    apb_write(32'hC, 32'hD);
    apb_read(32'hC, rd);
`ifdef SPI_SLV_IRQ_EN
    check("ctrl_ien", rd, 32'h0D);
    apb_write(32'hC, 32'h5);
    repeat (3) @(posedge PCLK);
    #1 check("irq_quiet", {31'h0, IRQ}, 32'h0);
    ss_low();
    spi_xfer(8'h99, 8, mi);
    ss_high();
    check("irq_rx", {31'h0, IRQ}, 32'h1);
    apb_read(32'h4, rd);  check("rx_99", rd, 32'h99);
    repeat (3) @(posedge PCLK);
    #1 check("irq_cleared", {31'h0, IRQ}, 32'h0);
`else
    check("ctrl_no_ien", rd, 32'h01);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
